rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 The module SHALL run on one clock, `clk`; reset `rst` SHALL be synchronous and active-high, sampled only on the rising edge of `clk`.
REQ-002 Parameter WIDTH, default 32: data width of each channel, legal range 1..64.
REQ-003 Parameter N, default 4: number of input channels, legal range 2..8.
REQ-004 Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-005 Derived constant SELW = max(1, clog2(N)).
REQ-006 Port `clk` -- input, 1 bit: clock.
REQ-007 Port `rst` -- input, 1 bit: synchronous active-high reset.
REQ-008 Port `in_data` -- input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port `in_valid` -- input, N bits: per-channel "data present".
REQ-010 Port `in_ready` -- output, N bits: per-channel accept strobe.
REQ-011 Port `out_data` -- output, WIDTH bits: registered selected data.
REQ-012 Port `out_sel` -- output, SELW bits: index of the channel that supplied `out_data`.
REQ-013 Port `out_valid` -- output, 1 bit: output register holds a beat.
REQ-014 Port `out_ready` -- input, 1 bit: downstream accepts the beat.

Function
REQ-015 `load_en` SHALL be defined as (!`out_valid` || `out_ready`); it is combinational.
REQ-016 Grant SHALL be a combinational one-hot vector, or zero when `in_valid` is zero.
  - MODE=1: grant goes to the lowest-index valid channel.
  - MODE=0: grant goes to the first valid channel searching upward from `ptr`, wrapping N-1 -> 0.
REQ-017 `in_ready[i]` SHALL equal `load_en` && grant[i]; a transfer on channel i occurs when `in_valid[i]` && `in_ready[i]`.
REQ-018 On a transfer at a rising edge:
  - `out_data` SHALL load `in_data` of channel i;
  - `out_sel` SHALL load i;
  - `out_valid` SHALL become 1.
  This gives one cycle of latency from input transfer to `out_valid`.
REQ-019 If `load_en` = 1 and no channel is valid, `out_valid` SHALL become 0 at the edge; `out_data` and `out_sel` SHALL hold their values.
REQ-020 If `out_valid` = 1 and `out_ready` = 0:
  - `out_data`, `out_sel` and `out_valid` SHALL hold;
  - all `in_ready` bits SHALL be 0.
REQ-021 If `out_valid` = 1, `out_ready` = 1 and a channel is valid in the same cycle, the beat SHALL be replaced back-to-back with no bubble, giving full throughput of 1 beat/cycle.
REQ-022 Internal pointer `ptr` (SELW bits, MODE=0 only):
  - SHALL update to (granted index + 1) mod N only on a transfer;
  - SHALL otherwise hold.
REQ-023 In MODE=1 `ptr` SHALL be unused and held at 0.
REQ-024 `in_ready` SHALL never depend combinationally on `in_data`.
REQ-025 Changes to `in_valid` without a transfer SHALL NOT alter `ptr`.

Reset
REQ-026 While `rst` = 1 at an edge, the following SHALL be cleared to 0 regardless of any other input:
  - `out_valid`;
  - `out_data`;
  - `out_sel`;
  - `ptr`.
REQ-027 While `rst` = 1, `in_ready` SHALL be 0, and no transfer SHALL be counted.
REQ-028 A reset asserted mid-stream SHALL discard any held beat; the first grant after reset in MODE=0 SHALL search from channel 0.

Verification
REQ-029 Round-robin throughput:
  - Setup: WIDTH=8, N=4, MODE=0; `in_valid`=4'b1111 held; channel i data = 8'hA0+i; `out_ready`=1.
  - Required: `out_sel` sequence 0,1,2,3,0 on consecutive cycles, with `out_data` A0,A1,A2,A3,A0.
REQ-030 Back-pressure:
  - Stimulus: `out_valid`=1 holding 8'hA2, then `out_ready`=0 for 3 cycles.
  - Required: `out_data`=8'hA2 stable, `in_ready`=4'b0000, `ptr` unchanged.
  - Then `out_ready`=1: next beat is from channel 3.
REQ-031 Wrap and sparse request:
  - Stimulus: `ptr`=3, `in_valid`=4'b0011.
  - Required: grant ch0, `ptr` becomes 1; next cycle grant ch1, `ptr` becomes 2.
REQ-032 Fixed priority:
  - Setup: MODE=1, `in_valid`=4'b1010, `out_ready`=1.
  - Required: every cycle `out_sel`=1; `in_ready`=4'b0010.
REQ-033 Drain:
  - Stimulus: `out_valid`=1, `in_valid`=0, `out_ready`=1.
  - Required: next cycle `out_valid`=0, with `out_data`/`out_sel` unchanged.
REQ-034 Reset mid-operation:
  - Stimulus: `rst`=1 for one cycle while `out_valid`=1, `ptr`=2, `in_valid`=4'b1111.
  - Required: next cycle `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0 during reset; the first post-reset grant is ch0.

Source files
------------

// File: rtl/rr_mux.sv
// Registered N-to-1 multiplexer with round-robin or fixed-priority arbitration.
// One beat is held in the output register, and it is replaced back-to-back when downstream accepts it.
module rr_mux #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   parameter  int MODE  = 0,
   localparam int SELW  = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_sel;
   logic             r_out_valid;
   logic [SELW-1:0]  r_ptr;

   logic             w_load_en;
   logic [N-1:0]     w_grant;
   logic [SELW-1:0]  w_gidx;
   logic             w_any;
   logic [WIDTH-1:0] w_sel_data;

   assign w_load_en = !r_out_valid || out_ready;

   // The search visits channels in priority order and keeps the first valid one;
   // in round-robin mode the order starts at r_ptr and wraps.
   always_comb begin
      logic [SELW-1:0] w_idx;
      w_grant = '0;
      w_gidx  = '0;
      w_any   = 1'b0;
      w_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (MODE == 1) begin
            w_idx = SELW'(k);
         end else begin
            w_idx = SELW'((32'(r_ptr) + k) % N);
         end
         if (!w_any && in_valid[w_idx]) begin
            w_any          = 1'b1;
            w_grant[w_idx] = 1'b1;
            w_gidx         = w_idx;
         end
      end
   end

   always_comb begin
      w_sel_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_grant[i]) begin
            w_sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = (rst || !w_load_en) ? '0 : w_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else if (w_load_en) begin
         if (w_any) begin
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_gidx;
            r_out_valid <= 1'b1;
            if (MODE == 0) begin
               r_ptr <= (w_gidx == SELW'(N - 1)) ? '0 : w_gidx + 1'b1;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux.sv
// Testbench for rr_mux: a round-robin instance and a fixed-priority instance share stimulus.
// Each cycle both instances are compared against a channel-search reference model.
module tb_rr_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic        out_ready;

   logic [3:0]  in_ready0, in_ready1;
   logic [7:0]  out_data0, out_data1;
   logic [1:0]  out_sel0, out_sel1;
   logic        out_valid0, out_valid1;

   int vectors = 0;
   int miscompares = 0;

   int mv[2], md[2], ms[2], mp[2];

   always #5 clk = ~clk;

   rr_mux #(.WIDTH(8), .N(4), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready0), .out_data(out_data0), .out_sel(out_sel0),
      .out_valid(out_valid0), .out_ready(out_ready)
   );

   rr_mux #(.WIDTH(8), .N(4), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1),
      .out_valid(out_valid1), .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First valid channel in priority order: lowest index, or upward from ptr with wrap.
   function automatic int pick(input int mode, input int ptr, input logic [3:0] v);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (mode == 1) ? k : (ptr + k) % 4;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // One clock: check in_ready ahead of the edge, advance the model, check registers after it.
   task automatic step();
      int          g[2];
      bit          ld[2];
      logic [3:0]  er;
      #1;
      for (int m = 0; m < 2; m++) begin
         ld[m] = (mv[m] == 0) || out_ready;
         g[m]  = pick(m, mp[m], in_valid);
         er    = (rst || !ld[m] || g[m] < 0) ? 4'b0000 : 4'(1 << g[m]);
         chk(m == 0 ? "rr_in_ready" : "fp_in_ready", m == 0 ? in_ready0 : in_ready1, er);
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            mv[m] = 0; md[m] = 0; ms[m] = 0; mp[m] = 0;
         end else if (ld[m]) begin
            if (g[m] >= 0) begin
               mv[m] = 1;
               md[m] = int'(in_data[g[m]*8 +: 8]);
               ms[m] = g[m];
               if (m == 0) mp[m] = (g[m] + 1) % 4;
            end else begin
               mv[m] = 0;
            end
         end
      end
      #1;
      chk("rr_out_valid", out_valid0, 64'(mv[0]));
      chk("rr_out_data",  out_data0,  64'(md[0]));
      chk("rr_out_sel",   out_sel0,   64'(ms[0]));
      chk("rr_ptr",       dut0.r_ptr, 64'(mp[0]));
      chk("fp_out_valid", out_valid1, 64'(mv[1]));
      chk("fp_out_data",  out_data1,  64'(md[1]));
      chk("fp_out_sel",   out_sel1,   64'(ms[1]));
      chk("fp_ptr",       dut1.r_ptr, 64'(0));
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] exp_seq [5];
      exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
      for (int m = 0; m < 2; m++) begin
         mv[m] = 0; md[m] = 0; ms[m] = 0; mp[m] = 0;
      end
      rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
      in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      step();
      step();
      chk("reset_out_valid", out_valid0, 0);
      chk("reset_out_data", out_data0, 0);
      chk("reset_ptr", dut0.r_ptr, 0);

      // Round-robin throughput with all channels requesting.
      rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("tput_sel", out_sel0, 64'(i % 4));
         chk("tput_data", out_data0, 64'(exp_seq[i]));
      end
      step();
      step();
      chk("bp_pre_data", out_data0, 8'hA2);

      // Back-pressure holds the beat and blocks all channels.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", in_ready0, 4'b0000);
         step();
         chk("bp_hold_data", out_data0, 8'hA2);
         chk("bp_hold_ptr", dut0.r_ptr, 3);
      end
      out_ready = 1'b1;
      step();
      chk("bp_resume_sel", out_sel0, 3);

      // Wrap with sparse requests.
      in_valid = 4'b0100;
      step();
      chk("wrap_setup_ptr", dut0.r_ptr, 3);
      in_valid = 4'b0011;
      step();
      chk("wrap_sel0", out_sel0, 0);
      chk("wrap_ptr1", dut0.r_ptr, 1);
      step();
      chk("wrap_sel1", out_sel0, 1);
      chk("wrap_ptr2", dut0.r_ptr, 2);

      // Drain.
      in_valid = 4'b0000;
      step();
      chk("drain_valid", out_valid0, 0);
      chk("drain_data", out_data0, 8'hA1);
      chk("drain_sel", out_sel0, 1);

      // Fixed priority.
      in_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("fp_ready_const", in_ready1, 4'b0010);
         step();
         chk("fp_sel_const", out_sel1, 1);
      end

      // Reset mid-stream with ptr=2 and a held beat.
      in_valid = 4'b0010;
      step();
      chk("rst_setup_ptr", dut0.r_ptr, 2);
      rst = 1'b1; in_valid = 4'b1111;
      #1;
      chk("rst_in_ready", in_ready0, 4'b0000);
      step();
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_out_data", out_data0, 0);
      chk("rst_out_sel", out_sel0, 0);
      rst = 1'b0;
      step();
      chk("post_rst_sel", out_sel0, 0);
      chk("post_rst_data", out_data0, 8'hA0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
